lcd_text_ctrl: RTL and testbench

Parametrised HD44780-compatible character-LCD controller that continuously refreshes a 1- or 2-line display from an internal writable character buffer. It replaces fixed, hard-coded message sequencing with a run-time character RAM, parametrised byte timing, a dedicated clear-command hold-off and status outputs. It sits between application logic, which writes characters, and the LCD pins.

---
 rtl/lcd_text_ctrl.sv | 259 +++++++++++++++++++++++++
 tb/tb_lcd_text_ctrl.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_text_ctrl.sv
// lcd_text_ctrl: HD44780-compatible character LCD controller.
// Holds a writable character buffer and refreshes it to the panel forever.
// Sequence: power-up wait, four init commands, then per line a DDRAM
// address command followed by that line's characters. Each byte transfer is
// SETUP (1 cycle) / HIGH (E=1) / LOW (E=0, stretched after the clear command).
module lcd_text_ctrl #(
  parameter int NUM_LINES       = 2,
  parameter int LINE_CHARS      = 16,
  parameter int INIT_WAIT_CYC   = 1000000,
  parameter int E_HIGH_CYC      = 1000000,
  parameter int E_LOW_CYC       = 1000000,
  parameter int CLEAR_EXTRA_CYC = 100000,
  localparam int DEPTH          = NUM_LINES * LINE_CHARS,
  localparam int AW             = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          char_we_i,
  input  logic [AW-1:0] char_addr_i,
  input  logic [7:0]    char_data_i,
  output logic [7:0]    lcd_data_o,
  output logic          lcd_e_o,
  output logic          lcd_rs_o,
  output logic          lcd_rw_o,
  output logic          lcd_on_o,
  output logic          lcd_blon_o,
  output logic          init_done_o,
  output logic          frame_o
);

  // One shared timer covers the power-up wait and every byte phase, so it
  // is sized for the longest of them.
  localparam int LOW_MAX = E_LOW_CYC + CLEAR_EXTRA_CYC;
  localparam int HL_MAX  = (E_HIGH_CYC > LOW_MAX) ? E_HIGH_CYC : LOW_MAX;
  localparam int T_MAX   = (INIT_WAIT_CYC > HL_MAX) ? INIT_WAIT_CYC : HL_MAX;
  localparam int TW      = $clog2(T_MAX + 1);
  localparam int CW      = (LINE_CHARS > 1) ? $clog2(LINE_CHARS) : 1;

  localparam logic [TW-1:0] WAIT_END = TW'(INIT_WAIT_CYC - 1);
  localparam logic [TW-1:0] HIGH_END = TW'(E_HIGH_CYC - 1);
  localparam logic [TW-1:0] LOW_END  = TW'(E_LOW_CYC - 1);
  localparam logic [TW-1:0] CLR_END  = TW'(LOW_MAX - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(LINE_CHARS - 1);
  localparam logic          LINE_LAST = (NUM_LINES == 2);
  localparam logic [7:0]    FUNC_SET = (NUM_LINES == 2) ? 8'h38 : 8'h30;

  // Sequencer states
  localparam logic [1:0] S_WAIT  = 2'd0;
  localparam logic [1:0] S_INIT  = 2'd1;
  localparam logic [1:0] S_LADDR = 2'd2;
  localparam logic [1:0] S_CHARS = 2'd3;

  // Byte transfer phases
  localparam logic [1:0] P_SETUP = 2'd0;
  localparam logic [1:0] P_HIGH  = 2'd1;
  localparam logic [1:0] P_LOW   = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [1:0]    phase_q, phase_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic          line_q, line_d;
  logic [CW-1:0] col_q, col_d;
  logic [7:0]    data_q, data_d;
  logic          rs_q, rs_d;
  logic          e_q, e_d;
  logic          done_q, done_d;
  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];

  logic [TW-1:0] low_end;
  logic          byte_done;
  logic          load_char;

  // Init command ROM, in issue order.
  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    init_cmd = FUNC_SET;
      2'd1:    init_cmd = 8'h0C;
      2'd2:    init_cmd = 8'h06;
      default: init_cmd = 8'h01;
    endcase
  endfunction

  // Buffer index of a (line, column) position.
  function automatic logic [AW-1:0] char_idx(input logic ln, input logic [CW-1:0] cl);
    char_idx = AW'(int'(ln) * LINE_CHARS + int'(cl));
  endfunction

  // The clear command needs a longer low phase before the panel accepts more.
  assign low_end = (!rs_q && (data_q == 8'h01)) ? CLR_END : LOW_END;

  // Buffer write port: out-of-range addresses are dropped.
  always_comb begin
    mem_d = mem_q;
    if (char_we_i && (int'(char_addr_i) < DEPTH)) begin
      mem_d[char_addr_i] = char_data_i;
    end
  end

  // NOTE: the buffer has a reset so the panel shows blanks until written;
  // that makes it a flop array rather than an inferable RAM.
  // Buffer storage.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h20;
    end else begin
      mem_q <= mem_d;
    end
  end

  // Sequencer and byte-phase timing; picks and latches the next byte.
  always_comb begin
    // NOTE: every variable gets a default here first; a path that leaves one
    // unassigned would infer a latch.
    state_d   = state_q;
    phase_d   = phase_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    line_d    = line_q;
    col_d     = col_q;
    data_d    = data_q;
    rs_d      = rs_q;
    e_d       = e_q;
    done_d    = done_q;
    byte_done = 1'b0;
    load_char = 1'b0;

    if (state_q == S_WAIT) begin
      if (cnt_q == WAIT_END) begin
        state_d = S_INIT;
        phase_d = P_SETUP;
        cnt_d   = '0;
        idx_d   = 2'd0;
        data_d  = init_cmd(2'd0);
        rs_d    = 1'b0;
      end else begin
        cnt_d = cnt_q + TW'(1);
      end
    end else begin
      case (phase_q)
        P_SETUP: begin
          phase_d = P_HIGH;
          e_d     = 1'b1;
          cnt_d   = '0;
        end
        P_HIGH: begin
          if (cnt_q == HIGH_END) begin
            phase_d = P_LOW;
            e_d     = 1'b0;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + TW'(1);
          end
        end
        P_LOW: begin
          if (cnt_q == low_end) begin
            byte_done = 1'b1;
            phase_d   = P_SETUP;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_q + TW'(1);
          end
        end
        default: phase_d = P_SETUP;
      endcase

      // At the end of a byte's low phase, the next byte's SETUP begins.
      if (byte_done) begin
        case (state_q)
          S_INIT: begin
            rs_d = 1'b0;
            if (idx_q == 2'd3) begin
              done_d  = 1'b1;
              state_d = S_LADDR;
              line_d  = 1'b0;
              data_d  = 8'h80;
            end else begin
              idx_d  = idx_q + 2'd1;
              data_d = init_cmd(idx_q + 2'd1);
            end
          end
          S_LADDR: begin
            state_d   = S_CHARS;
            col_d     = '0;
            rs_d      = 1'b1;
            load_char = 1'b1;
          end
          S_CHARS: begin
            if (col_q != COL_LAST) begin
              col_d     = col_q + CW'(1);
              rs_d      = 1'b1;
              load_char = 1'b1;
            end else begin
              state_d = S_LADDR;
              rs_d    = 1'b0;
              if (line_q != LINE_LAST) begin
                line_d = line_q + 1'b1;
                data_d = 8'hC0;
              end else begin
                line_d = 1'b0;
                data_d = 8'h80;
              end
            end
          end
          default: state_d = S_WAIT;
        endcase
      end
    end

    // The character is captured at the edge that opens its SETUP cycle, so a
    // write landing during SETUP only shows up on the next frame.
    if (load_char) begin
      data_d = mem_q[char_idx(line_d, col_d)];
    end
  end

  // Sequencer registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_WAIT;
      phase_q <= P_SETUP;
      cnt_q   <= '0;
      idx_q   <= 2'd0;
      line_q  <= 1'b0;
      col_q   <= '0;
      data_q  <= 8'h00;
      rs_q    <= 1'b0;
      e_q     <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop
      // samples the pre-edge values computed above.
      state_q <= state_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      line_q  <= line_d;
      col_q   <= col_d;
      data_q  <= data_d;
      rs_q    <= rs_d;
      e_q     <= e_d;
      done_q  <= done_d;
    end
  end

  assign lcd_data_o  = data_q;
  assign lcd_e_o     = e_q;
  assign lcd_rs_o    = rs_q;
  assign lcd_rw_o    = 1'b0;
  assign lcd_on_o    = 1'b1;
  assign lcd_blon_o  = 1'b1;
  assign init_done_o = done_q;
  // High during the final low-phase cycle of the last character of a frame.
  assign frame_o     = (state_q == S_CHARS) && (phase_q == P_LOW) &&
                       (cnt_q == low_end) && (col_q == COL_LAST) &&
                       (line_q == LINE_LAST);

endmodule

// File: tb/tb_lcd_text_ctrl.sv
// tb_lcd_text_ctrl: three controller instances sharing one clock.
//   A: 2 lines x 4 chars, slow timing (init, frames, reset, collision).
//   B: 1 line  x 4 chars, same timing (function set, period, buffer loss).
//   C: 2 lines x 3 chars, fast timing (random writes vs frame model,
//      including addresses 6 and 7 which lie beyond the buffer).
`timescale 1ns/1ps
module tb_lcd_text_ctrl;

  localparam int IW = 20;
  localparam int EH = 4;
  localparam int EL = 6;
  localparam int CX = 10;
  localparam int BP = 1 + EH + EL;   // byte period, 11
  localparam int C_LC = 3;
  localparam int C_DEPTH = 2 * C_LC;

  typedef logic [8:0] byteq_t [$];
  typedef logic [7:0] mem8_t [8];

  typedef struct {
    logic [2:0] addr;
    logic [7:0] data;
    int         pos;   // index in the captured byte stream after reset
    logic [8:0] exp;   // {rs, data} expected at that index
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected frame: per line the DDRAM address command, then its characters.
  function automatic byteq_t frame_model(input int nl, input int lc, input mem8_t m);
    byteq_t q;
    for (int l = 0; l < nl; l++) begin
      q.push_back({1'b0, 8'(8'h80 + 8'h40 * l)});
      for (int c = 0; c < lc; c++) q.push_back({1'b1, m[l * lc + c]});
    end
    return q;
  endfunction

  // ---------------- DUT A ----------------
  logic       rst_a = 1'b0, we_a = 1'b0;
  logic [2:0] addr_a = '0;
  logic [7:0] wd_a = '0, data_a;
  logic       e_a, rs_a, rw_a, on_a, blon_a, done_a, frame_a;

  lcd_text_ctrl #(.NUM_LINES(2), .LINE_CHARS(4), .INIT_WAIT_CYC(IW),
                  .E_HIGH_CYC(EH), .E_LOW_CYC(EL), .CLEAR_EXTRA_CYC(CX)) u_a (
    .clk_i(clk), .rst_ni(rst_a), .char_we_i(we_a), .char_addr_i(addr_a),
    .char_data_i(wd_a), .lcd_data_o(data_a), .lcd_e_o(e_a), .lcd_rs_o(rs_a),
    .lcd_rw_o(rw_a), .lcd_on_o(on_a), .lcd_blon_o(blon_a),
    .init_done_o(done_a), .frame_o(frame_a));

  // ---------------- DUT B ----------------
  logic       rst_b = 1'b0, we_b = 1'b0;
  logic [1:0] addr_b = '0;
  logic [7:0] wd_b = '0, data_b;
  logic       e_b, rs_b, rw_b, on_b, blon_b, done_b, frame_b;

  lcd_text_ctrl #(.NUM_LINES(1), .LINE_CHARS(4), .INIT_WAIT_CYC(IW),
                  .E_HIGH_CYC(EH), .E_LOW_CYC(EL), .CLEAR_EXTRA_CYC(CX)) u_b (
    .clk_i(clk), .rst_ni(rst_b), .char_we_i(we_b), .char_addr_i(addr_b),
    .char_data_i(wd_b), .lcd_data_o(data_b), .lcd_e_o(e_b), .lcd_rs_o(rs_b),
    .lcd_rw_o(rw_b), .lcd_on_o(on_b), .lcd_blon_o(blon_b),
    .init_done_o(done_b), .frame_o(frame_b));

  // ---------------- DUT C ----------------
  logic       rst_c = 1'b0, we_c = 1'b0;
  logic [2:0] addr_c = '0;
  logic [7:0] wd_c = '0, data_c;
  logic       e_c, rs_c, rw_c, on_c, blon_c, done_c, frame_c;

  lcd_text_ctrl #(.NUM_LINES(2), .LINE_CHARS(C_LC), .INIT_WAIT_CYC(5),
                  .E_HIGH_CYC(1), .E_LOW_CYC(1), .CLEAR_EXTRA_CYC(2)) u_c (
    .clk_i(clk), .rst_ni(rst_c), .char_we_i(we_c), .char_addr_i(addr_c),
    .char_data_i(wd_c), .lcd_data_o(data_c), .lcd_e_o(e_c), .lcd_rs_o(rs_c),
    .lcd_rw_o(rw_c), .lcd_on_o(on_c), .lcd_blon_o(blon_c),
    .init_done_o(done_c), .frame_o(frame_c));

  // ---------------- monitors (sample on falling edge) ----------------
  logic   pe_a = 1'b0, pd_a = 1'b0, pe_b = 1'b0, pe_c = 1'b0;
  logic [8:0] qa[$], qb[$], qc[$];
  int     ta[$], fall_a[$], fa_t[$], fb_t[$], fc_t[$];
  int     done_t_a = -1;

  always @(negedge clk) begin
    if (e_a && !pe_a) begin qa.push_back({rs_a, data_a}); ta.push_back(cyc); end
    if (!e_a && pe_a) fall_a.push_back(cyc);
    if (frame_a) fa_t.push_back(cyc);
    if (done_a && !pd_a) done_t_a <= cyc;
    pe_a <= e_a;
    pd_a <= done_a;
  end

  always @(negedge clk) begin
    if (e_b && !pe_b) qb.push_back({rs_b, data_b});
    if (frame_b) fb_t.push_back(cyc);
    pe_b <= e_b;
  end

  always @(negedge clk) begin
    if (e_c && !pe_c) qc.push_back({rs_c, data_c});
    if (frame_c) fc_t.push_back(cyc);
    pe_c <= e_c;
  end

  function automatic int frame_count(input int which);
    if (which == 0) return fa_t.size();
    if (which == 1) return fb_t.size();
    return fc_t.size();
  endfunction

  // Wait (bounded) until the given instance has reported `target` frames.
  task automatic wait_frames(input int which, input int target, input int limit, input string name);
    int g = 0;
    while (frame_count(which) < target && g < limit) begin
      @(posedge clk);
      g++;
    end
    check({name, " frame wait"}, 32'(frame_count(which) >= target), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t   vecs[8];
    mem8_t  blank, m_a, m_c;
    byteq_t exp_q;
    int     rel, n, base, cnt_c0, found;
    logic [2:0] ra;
    logic [7:0] rd;

    vecs[0] = '{3'd0, "L", 5,  {1'b1, 8'h4C}};
    vecs[1] = '{3'd1, "o", 6,  {1'b1, 8'h6F}};
    vecs[2] = '{3'd2, "g", 7,  {1'b1, 8'h67}};
    vecs[3] = '{3'd3, "2", 8,  {1'b1, 8'h32}};
    vecs[4] = '{3'd4, "=", 10, {1'b1, 8'h3D}};
    vecs[5] = '{3'd5, "1", 11, {1'b1, 8'h31}};
    vecs[6] = '{3'd6, ".", 12, {1'b1, 8'h2E}};
    vecs[7] = '{3'd7, "5", 13, {1'b1, 8'h35}};
    blank = '{default: 8'h20};

    // ---- reset values ----
    repeat (3) @(posedge clk);
    #1;
    check("rst data", data_a, 8'h00);
    check("rst e", e_a, 0);
    check("rst rs", rs_a, 0);
    check("rst rw", rw_a, 0);
    check("rst on", on_a, 1);
    check("rst blon", blon_a, 1);
    check("rst init_done", done_a, 0);
    check("rst frame", frame_a, 0);

    @(posedge clk);
    #2;
    rel = cyc;
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;

    // ---- A: init sequence and blank frames ----
    wait_frames(0, 3, 1000, "A blank");
    check("A first E rise", ta[0] - rel, IW + 1);
    check("A byte0", qa[0], 9'h038);
    check("A byte1", qa[1], 9'h00C);
    check("A byte2", qa[2], 9'h006);
    check("A byte3", qa[3], 9'h001);
    check("A E high width", fall_a[0] - ta[0], EH);
    check("A byte period", ta[1] - ta[0], BP);
    check("A clear gap", ta[4] - ta[3], BP + CX);
    check("A init_done time", done_t_a - rel, IW + 3 * BP + BP + CX);
    check("A init_done vs 0x80 setup", ta[4] - done_t_a, 1);
    exp_q = frame_model(2, 4, blank);
    for (int i = 0; i < 10; i++) check($sformatf("A blank frame byte %0d", i), qa[4 + i], exp_q[i]);
    check("A frame2 starts 0x80", qa[14], 9'h080);
    check("A frame pulse before 0x80", ta[14] - fa_t[0], 2);
    check("A frame period 1", fa_t[1] - fa_t[0], 10 * BP);
    check("A frame period 2", fa_t[2] - fa_t[1], 10 * BP);

    // ---- B: single line ----
    wait_frames(1, 3, 1000, "B blank");
    check("B function set", qb[0], 9'h030);
    exp_q = frame_model(1, 4, blank);
    for (int i = 0; i < 5; i++) check($sformatf("B frame byte %0d", i), qb[4 + i], exp_q[i]);
    check("B next frame 0x80", qb[9], 9'h080);
    cnt_c0 = 0;
    foreach (qb[i]) if (qb[i] == 9'h0C0) cnt_c0++;
    check("B no 0xC0", cnt_c0, 0);
    check("B frame period", fb_t[1] - fb_t[0], 5 * BP);
    check("B frame period 2", fb_t[2] - fb_t[1], 5 * BP);

    // ---- B: buffer contents lost on reset ----
    @(posedge clk); #1;
    we_b = 1'b1; addr_b = 2'd1; wd_b = 8'h5A;
    @(posedge clk); #1;
    we_b = 1'b0;
    wait_frames(1, fb_t.size() + 2, 300, "B write");
    base = qb.size() - 5;
    check("B written char", qb[base + 2], 9'h15A);
    #1 rst_b = 1'b0;
    @(posedge clk); @(posedge clk); #2;
    qb.delete(); fb_t.delete();
    rst_b = 1'b1;
    wait_frames(1, 1, 400, "B after reset");
    check("B re-init function set", qb[0], 9'h030);
    for (int i = 0; i < 5; i++) check($sformatf("B post-reset byte %0d", i), qb[4 + i], exp_q[i]);

    // ---- A: reset during HIGH phase ----
    found = 0;
    for (int g = 0; g < 100 && found == 0; g++) begin
      @(negedge clk);
      if (e_a) found = 1;
    end
    check("A found HIGH phase", found, 1);
    check("A init_done before reset", done_a, 1);
    #1 rst_a = 1'b0;
    #1;
    check("A E low at reset", e_a, 0);
    check("A init_done low at reset", done_a, 0);
    check("A data cleared at reset", data_a, 8'h00);
    @(posedge clk); @(posedge clk); #2;
    qa.delete(); ta.delete(); fall_a.delete(); fa_t.delete();
    done_t_a = -1;
    rel = cyc;
    rst_a = 1'b1;

    // Table writes during WAIT.
    for (int i = 0; i < 8; i++) begin
      we_a = 1'b1; addr_a = vecs[i].addr; wd_a = vecs[i].data;
      @(posedge clk); #1;
    end
    we_a = 1'b0;
    wait_frames(0, 1, 400, "A text");
    check("A re-sent 0x38", qa[0], 9'h038);
    check("A re-init E rise", ta[0] - rel, IW + 1);
    for (int i = 0; i < 8; i++)
      check($sformatf("A text addr %0d", vecs[i].addr), qa[vecs[i].pos], vecs[i].exp);

    // ---- A: write during the SETUP of address 2 ----
    found = 0;
    for (int g = 0; g < 200 && found == 0; g++) begin
      @(negedge clk);
      if (rs_a && !e_a && data_a == 8'h67) found = 1;
    end
    check("A collision setup found", found, 1);
    n = qa.size();
    we_a = 1'b1; addr_a = 3'd2; wd_a = 8'h41;
    @(posedge clk); #1;
    we_a = 1'b0;
    wait_frames(0, 3, 400, "A collision");
    check("A collision old value", qa[n], 9'h167);
    for (int i = 0; i < 8; i++) m_a[i] = vecs[i].data;
    m_a[2] = 8'h41;
    exp_q = frame_model(2, 4, m_a);
    for (int i = 0; i < 10; i++) check($sformatf("A next frame byte %0d", i), qa[n + 7 + i], exp_q[i]);

    // ---- C: random writes vs frame model ----
    wait_frames(2, 1, 300, "C start");
    m_c = blank;
    for (int r = 0; r < 25; r++) begin
      n = (r == 0) ? 3 : int'($urandom_range(1, 6));
      for (int k = 0; k < n; k++) begin
        ra = (r == 0 && k < 2) ? 3'(6 + k) : 3'($urandom_range(0, 7));
        rd = 8'($urandom_range(8'h21, 8'h7E));
        we_c = 1'b1; addr_c = ra; wd_c = rd;
        @(posedge clk); #1;
        if (int'(ra) < C_DEPTH) m_c[ra] = rd;
      end
      we_c = 1'b0;
      wait_frames(2, fc_t.size() + 2, 200, $sformatf("C round %0d", r));
      base = qc.size() - 2 * (C_LC + 1);
      exp_q = frame_model(2, C_LC, m_c);
      for (int i = 0; i < 2 * (C_LC + 1); i++)
        check($sformatf("C round %0d byte %0d", r, i), qc[base + i], exp_q[i]);
    end

    check("A rw stays low", rw_a, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
